// File: rtl/comparator_control_pkg.sv
// rtl/comparator_control_pkg.sv - comparator operation codes (branch funct3 encoding)
package comparator_control_pkg;
  import core_pkg::*;
  localparam logic [COMPARATOR_WIDTH_CODE-1:0] CMP_BEQ  = 3'b000;
  localparam logic [COMPARATOR_WIDTH_CODE-1:0] CMP_BNE  = 3'b001;
  localparam logic [COMPARATOR_WIDTH_CODE-1:0] CMP_BLT  = 3'b100;
  localparam logic [COMPARATOR_WIDTH_CODE-1:0] CMP_BGE  = 3'b101;
  localparam logic [COMPARATOR_WIDTH_CODE-1:0] CMP_BLTU = 3'b110;
  localparam logic [COMPARATOR_WIDTH_CODE-1:0] CMP_BGEU = 3'b111;
endpackage

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - core-wide datapath widths
package core_pkg;
  parameter int DATA_WIDTH            = 32;
  parameter int COMPARATOR_WIDTH_CODE = 3;
endpackage

// File: rtl/core_branch_ctrl_if.sv
// rtl/core_branch_ctrl_if.sv - issue/fetch/writeback signals of the branch controller
// master: issue + fetch side (drives br_*, redirect_ready)
// slave:  branch controller (drives br_ready, redirect_*, flush, link_*, misalign_err)
interface core_branch_ctrl_if;
  logic                                       br_valid;
  logic                                       br_ready;
  logic [core_pkg::COMPARATOR_WIDTH_CODE-1:0] br_control;
  logic                                       br_is_jal;
  logic                                       br_is_jalr;
  logic [core_pkg::DATA_WIDTH-1:0]            br_pc;
  logic [core_pkg::DATA_WIDTH-1:0]            br_imm;
  logic [core_pkg::DATA_WIDTH-1:0]            br_rs1;
  logic [core_pkg::DATA_WIDTH-1:0]            br_rs2;
  logic                                       redirect_valid;
  logic                                       redirect_ready;
  logic [core_pkg::DATA_WIDTH-1:0]            redirect_pc;
  logic                                       flush;
  logic                                       link_valid;
  logic [core_pkg::DATA_WIDTH-1:0]            link_data;
  logic                                       misalign_err;

  modport master (
    output br_valid, br_control, br_is_jal, br_is_jalr, br_pc, br_imm, br_rs1, br_rs2,
    output redirect_ready,
    input  br_ready, redirect_valid, redirect_pc, flush, link_valid, link_data, misalign_err
  );

  modport slave (
    input  br_valid, br_control, br_is_jal, br_is_jalr, br_pc, br_imm, br_rs1, br_rs2,
    input  redirect_ready,
    output br_ready, redirect_valid, redirect_pc, flush, link_valid, link_data, misalign_err
  );
endinterface

// File: rtl/comparator.sv
// rtl/comparator.sv - execution-stage branch comparator
// Ports: control (op code), a/b (operands), out (condition true).
// Unknown codes evaluate to false.
module comparator
  import core_pkg::*;
  import comparator_control_pkg::*;
(
  input  logic [COMPARATOR_WIDTH_CODE-1:0] control,
  input  logic [DATA_WIDTH-1:0]            a,
  input  logic [DATA_WIDTH-1:0]            b,
  output logic                             out
);
  always_comb begin
    out = 1'b0;
    case (control)
      CMP_BEQ:  out = (a == b);
      CMP_BNE:  out = (a != b);
      CMP_BLT:  out = ($signed(a) < $signed(b));
      CMP_BGE:  out = ($signed(a) >= $signed(b));
      CMP_BLTU: out = (a < b);
      CMP_BGEU: out = (a >= b);
      default:  out = 1'b0;
    endcase
  end
endmodule

// File: rtl/core_branch_ctrl.sv
// rtl/core_branch_ctrl.sv - branch/jump resolution, fetch redirect and pipeline flush
// Ports: clk, rst (sync, active-high), bus (core_branch_ctrl_if.slave):
//   br_* issue handshake, redirect_* fetch handshake, flush, link_* writeback, misalign_err.
module core_branch_ctrl
  import core_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input logic               clk,
  input logic               rst,
  core_branch_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RESOLVE, REDIRECT, FLUSH} state_t;

  state_t                           state_q, state_d;
  logic [COMPARATOR_WIDTH_CODE-1:0] ctrl_q;
  logic                             jal_q, jalr_q;
  logic [DATA_WIDTH-1:0]            pc_q, imm_q, rs1_q, rs2_q;
  logic [3:0]                       cnt_q;
  logic [DATA_WIDTH-1:0]            redirect_pc_q, link_data_q;
  logic                             link_valid_q, misalign_q;

  logic                             cmp_out, taken, aligned;
  logic [DATA_WIDTH-1:0]            target;

  // Comparator sees only captured operands so issue may change br_* freely.
  comparator u_cmp (
    .control (ctrl_q),
    .a       (rs1_q),
    .b       (rs2_q),
    .out     (cmp_out)
  );

  assign taken   = jal_q | jalr_q | cmp_out;
  // jalr wins when both jump flags are set; its target drops bit 0.
  assign target  = jalr_q ? ((rs1_q + imm_q) & {{(DATA_WIDTH-1){1'b1}}, 1'b0})
                          : (pc_q + imm_q);
  assign aligned = (target[1:0] == 2'b00);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.br_valid) state_d = RESOLVE;
      RESOLVE:  state_d = (taken && aligned) ? REDIRECT : IDLE;
      REDIRECT: if (bus.redirect_ready) state_d = FLUSH;
      FLUSH:    if (cnt_q == 4'd0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign bus.br_ready       = (state_q == IDLE);
  assign bus.redirect_valid = (state_q == REDIRECT);
  assign bus.flush          = (state_q == FLUSH);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.link_valid     = link_valid_q;
  assign bus.link_data      = link_data_q;
  assign bus.misalign_err   = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ctrl_q        <= '0;
      jal_q         <= 1'b0;
      jalr_q        <= 1'b0;
      pc_q          <= '0;
      imm_q         <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      cnt_q         <= '0;
      redirect_pc_q <= '0;
      link_data_q   <= '0;
      link_valid_q  <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      link_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.br_valid) begin
            ctrl_q <= bus.br_control;
            jal_q  <= bus.br_is_jal;
            jalr_q <= bus.br_is_jalr;
            pc_q   <= bus.br_pc;
            imm_q  <= bus.br_imm;
            rs1_q  <= bus.br_rs1;
            rs2_q  <= bus.br_rs2;
          end
        end
        RESOLVE: begin
          if (jal_q || jalr_q) begin
            link_valid_q <= 1'b1;
            link_data_q  <= pc_q + DATA_WIDTH'(4);
          end
          // Target is recorded even when misaligned so the faulting address is visible.
          if (taken) begin
            redirect_pc_q <= target;
            misalign_q    <= !aligned;
          end
        end
        REDIRECT: begin
          if (bus.redirect_ready) cnt_q <= 4'(FLUSH_CYCLES - 1);
        end
        FLUSH: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_core_branch_ctrl.sv
// tb/tb_core_branch_ctrl.sv - scoreboard bench for core_branch_ctrl
module tb_core_branch_ctrl;
  localparam int EV_LINK = 0, EV_MIS = 1, EV_REDIR = 2, EV_FLUSH = 3;
  localparam int K_NT = 0, K_TAKEN = 1, K_MIS = 2;
  localparam logic [2:0] C_BEQ = 3'b000, C_BNE = 3'b001, C_BLT = 3'b100,
                         C_BLTU = 3'b110, C_UNK = 3'b010;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   run_len = 0;
  ev_t  q[$];

  core_branch_ctrl_if bus();

  core_branch_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [31:0] data, input string name);
    ev_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL %s: unexpected event data %h, expected no event", name, data);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.data !== data) begin
        fails++;
        $display("FAIL %s: got kind %0d data %h expected kind %0d data %h",
                 name, kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: observed events in a fixed per-cycle order matching push order.
  always @(negedge clk) begin
    if (bus.link_valid === 1'b1) check_ev(EV_LINK, bus.link_data, "link");
    if (bus.misalign_err === 1'b1) check_ev(EV_MIS, bus.redirect_pc, "misalign");
    if (bus.redirect_valid === 1'b1 && bus.redirect_ready === 1'b1)
      check_ev(EV_REDIR, bus.redirect_pc, "redirect");
    if (bus.flush === 1'b1) run_len++;
    else if (run_len > 0) begin
      check_ev(EV_FLUSH, 32'(run_len), "flush_len");
      run_len = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] ctrl, input logic jal, input logic jalr,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    int k = 0;
    while (bus.br_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk("issue_ready", bus.br_ready, 1'b1);
    bus.br_control = ctrl;
    bus.br_is_jal  = jal;
    bus.br_is_jalr = jalr;
    bus.br_pc      = pc;
    bus.br_imm     = imm;
    bus.br_rs1     = rs1;
    bus.br_rs2     = rs2;
    bus.br_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.br_valid = 1'b0;
  endtask

  // Returns in cycle N+5 (taken) or N+2 (otherwise), relative to accept edge N.
  task automatic run_br(input string name, input logic [2:0] ctrl, input logic jal,
                        input logic jalr, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input int kind, input logic [31:0] tgt, input logic [31:0] lnk);
    if (jal || jalr) push(EV_LINK, lnk);
    if (kind == K_MIS) push(EV_MIS, tgt);
    if (kind == K_TAKEN) begin
      push(EV_REDIR, tgt);
      push(EV_FLUSH, 32'd2);
    end
    bus.redirect_ready = 1'b1;
    issue(ctrl, jal, jalr, pc, imm, rs1, rs2);
    chk({name, "_resolve_busy"}, bus.br_ready, 1'b0);
    step();
    if (kind == K_TAKEN) begin
      chk({name, "_redir_valid"}, bus.redirect_valid, 1'b1);
      chk({name, "_redir_pc"}, bus.redirect_pc, tgt);
      step();
      chk({name, "_flush"}, bus.flush, 1'b1);
      step();
      chk({name, "_busy_n4"}, bus.br_ready, 1'b0);
      step();
      chk({name, "_ready_n5"}, bus.br_ready, 1'b1);
    end else begin
      chk({name, "_ready_n2"}, bus.br_ready, 1'b1);
      chk({name, "_no_redir"}, bus.redirect_valid, 1'b0);
      chk({name, "_no_flush"}, bus.flush, 1'b0);
    end
  endtask

  initial begin
    bus.br_valid = 1'b0; bus.br_control = '0; bus.br_is_jal = 1'b0; bus.br_is_jalr = 1'b0;
    bus.br_pc = '0; bus.br_imm = '0; bus.br_rs1 = '0; bus.br_rs2 = '0;
    bus.redirect_ready = 1'b1;
    step();
    step();
    chk("rst_br_ready", bus.br_ready, 1'b1);
    chk("rst_redir_valid", bus.redirect_valid, 1'b0);
    chk("rst_flush", bus.flush, 1'b0);
    chk("rst_link_valid", bus.link_valid, 1'b0);
    chk("rst_misalign", bus.misalign_err, 1'b0);
    chk("rst_redir_pc", bus.redirect_pc, 32'h0);
    chk("rst_link_data", bus.link_data, 32'h0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", bus.br_ready, 1'b1);

    run_br("beq_t",   C_BEQ,  1'b0, 1'b0, 32'h100, 32'h20, 32'd5, 32'd5, K_TAKEN, 32'h120, 32'h0);
    run_br("beq_nt",  C_BEQ,  1'b0, 1'b0, 32'h100, 32'h20, 32'd5, 32'd6, K_NT,    32'h0,   32'h0);
    run_br("blt_t",   C_BLT,  1'b0, 1'b0, 32'h400, 32'h10, 32'hFFFF_FFFF, 32'd1, K_TAKEN, 32'h410, 32'h0);
    run_br("bltu_nt", C_BLTU, 1'b0, 1'b0, 32'h400, 32'h10, 32'hFFFF_FFFF, 32'd1, K_NT, 32'h0, 32'h0);
    run_br("jalr_mis", C_BEQ, 1'b0, 1'b1, 32'h200, 32'h4, 32'h1003, 32'h0, K_MIS, 32'h1006, 32'h204);
    run_br("jalr_ok", C_BEQ,  1'b0, 1'b1, 32'h200, 32'h3, 32'h1001, 32'h0, K_TAKEN, 32'h1004, 32'h204);
    run_br("unk_nt",  C_UNK,  1'b0, 1'b0, 32'h100, 32'h20, 32'd5, 32'd5, K_NT, 32'h0, 32'h0);
    run_br("jal_wrap", C_BNE, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0, K_TAKEN, 32'h10, 32'hFFFF_FFF4);
    run_br("both_jmp", C_BEQ, 1'b1, 1'b1, 32'h600, 32'h10, 32'h2000, 32'h0, K_TAKEN, 32'h2010, 32'h604);

    // Backpressure: fetch stalls five cycles; a stray jal offered mid-stall must vanish.
    push(EV_REDIR, 32'h340);
    push(EV_FLUSH, 32'd2);
    bus.redirect_ready = 1'b0;
    issue(C_BNE, 1'b0, 1'b0, 32'h300, 32'h40, 32'd1, 32'd2);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", bus.redirect_valid, 1'b1);
      chk("stall_pc", bus.redirect_pc, 32'h340);
      chk("stall_busy", bus.br_ready, 1'b0);
      if (i == 1) begin
        bus.br_control = C_BEQ; bus.br_is_jal = 1'b1; bus.br_is_jalr = 1'b0;
        bus.br_pc = 32'h0; bus.br_imm = 32'h8; bus.br_valid = 1'b1;
      end else begin
        bus.br_valid = 1'b0;
      end
      step();
    end
    bus.redirect_ready = 1'b1;
    step();
    chk("stall_flush", bus.flush, 1'b1);
    step();
    step();
    chk("stall_ready", bus.br_ready, 1'b1);

    // Reset in the first flush cycle; a jal offered during reset must be ignored.
    push(EV_REDIR, 32'h508);
    push(EV_FLUSH, 32'd1);
    issue(C_BEQ, 1'b0, 1'b0, 32'h500, 32'h8, 32'd7, 32'd7);
    step();
    chk("rflush_redir", bus.redirect_valid, 1'b1);
    step();
    chk("rflush_flush1", bus.flush, 1'b1);
    rst = 1'b1;
    bus.br_is_jal = 1'b1; bus.br_pc = 32'h700; bus.br_imm = 32'h4; bus.br_valid = 1'b1;
    step();
    chk("rflush_flush0", bus.flush, 1'b0);
    chk("rflush_redir0", bus.redirect_valid, 1'b0);
    chk("rflush_link0", bus.link_valid, 1'b0);
    rst = 1'b0;
    bus.br_valid = 1'b0;
    step();
    chk("rflush_ready", bus.br_ready, 1'b1);
    step();
    step();
    step();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/core_branch_ctrl.md
CORE_BRANCH_CTRL -- requirements
Module: core_branch_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, the number of cycles flush is held after a redirect is accepted (legal range 1..15).
REQ-002 SHALL use DATA_WIDTH (32) and COMPARATOR_WIDTH_CODE from core_pkg, and comparator codes from comparator_control_pkg.
REQ-003 SHALL have port clk  input  1  clock; the only clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port br_valid  input  1  branch or jump offered by issue.
REQ-006 SHALL have port br_ready  output  1  controller can accept a branch or jump.
REQ-007 SHALL have port br_control  input  COMPARATOR_WIDTH_CODE  comparator operation code.
REQ-008 SHALL have ports br_is_jal and br_is_jalr  input  1 each  unconditional jump flags.
REQ-009 SHALL have ports br_pc, br_imm, br_rs1 and br_rs2  input  DATA_WIDTH each  instruction PC, sign-extended immediate, and operands.
REQ-010 SHALL have port redirect_valid  output  1  redirect request to fetch.
REQ-011 SHALL have port redirect_ready  input  1  fetch accepts the redirect.
REQ-012 SHALL have port redirect_pc  output  DATA_WIDTH  redirect target.
REQ-013 SHALL have port flush  output  1  squash of younger instructions.
REQ-014 SHALL have ports link_valid (output, 1) and link_data (output, DATA_WIDTH)  one-cycle writeback of pc+4 for jal/jalr.
REQ-015 SHALL have port misalign_err  output  1  one-cycle pulse when a taken target is misaligned.

Function
REQ-016 SHALL instantiate the existing execution-stage comparator and drive it only from captured registers, never from the br_* inputs directly.
REQ-017 SHALL implement the FSM states IDLE, RESOLVE, REDIRECT and FLUSH; br_ready SHALL be 1 only in IDLE.
REQ-018 SHALL, in IDLE on br_valid&&br_ready, capture control, flags, pc, imm, rs1 and rs2, and go to RESOLVE on the next edge.
REQ-019 SHALL, in RESOLVE (exactly 1 cycle), compute taken = br_is_jal | br_is_jalr | comparator_out.
REQ-020 SHALL compute the target as (rs1+imm) & ~1 when jalr is set (jalr has priority if both flags are set), else pc+imm; all additions are modulo 2^32 with no overflow flag.
REQ-021 SHALL, in RESOLVE, pulse link_valid for 1 cycle with link_data = pc+4 (modulo 2^32) when jal or jalr is set, including when the target is misaligned.
REQ-022 SHALL, in RESOLVE, go to IDLE when not taken, with no redirect and no flush.
REQ-023 SHALL, when taken and target[1:0] != 0, pulse misalign_err the next cycle and go to IDLE with no redirect.
REQ-024 SHALL, when taken and the target is aligned, register the target into redirect_pc and go to REDIRECT.
REQ-025 SHALL, in REDIRECT, hold redirect_valid=1 and redirect_pc stable until redirect_ready is sampled high; on that edge it goes to FLUSH.
REQ-026 SHALL, in FLUSH, hold flush=1 for exactly FLUSH_CYCLES cycles using a down-counter, then go to IDLE.
REQ-027 SHALL treat a branch with no jump flag and an unknown comparator code as not taken.
REQ-028 SHALL ignore br_valid outside IDLE: no capture and no side effects.
REQ-029 SHALL give accept-to-redirect latency as: accept at edge N, RESOLVE in cycle N+1, redirect_valid high from cycle N+2.
REQ-030 SHALL give the earliest re-accept as cycle N+3+FLUSH_CYCLES when fetch is ready immediately, and cycle N+2 for a not-taken branch.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, enter IDLE; clear the counter and captured registers; and set redirect_valid, flush, link_valid and misalign_err to 0 and redirect_pc and link_data to 0.
REQ-032 SHALL apply reset from any state, including mid-REDIRECT and mid-FLUSH, with outputs deasserted on that same edge; br_ready SHALL be 1 the first cycle after reset is released.
REQ-033 SHALL ignore br_valid while rst=1.

Verification
REQ-034 SHALL cover beq taken: pc=0x100, imm=0x20, rs1=rs2=5 -> redirect_valid at N+2 with redirect_pc=0x120; with redirect_ready=1, flush is high for 2 cycles and br_ready returns at N+5.
REQ-035 SHALL cover blt signed compare: rs1=0xFFFFFFFF, rs2=1 -> taken; bltu with the same operands -> not taken, br_ready=1 at N+2, and flush never asserts.
REQ-036 SHALL cover jalr: rs1=0x1003, imm=0x4, pc=0x200 -> link_valid with link_data=0x204, and redirect_pc=0x1006 with misalign_err=1 and no redirect; with rs1=0x1001, imm=0x3 -> redirect_pc=0x1004.
REQ-037 SHALL cover a backpressure stall: redirect_ready=0 for 5 cycles -> redirect_valid and redirect_pc stay stable, and a br_valid pulse during the stall is ignored.
REQ-038 SHALL cover wrap-around: pc=0xFFFFFFF0, imm=0x20, jal -> redirect_pc=0x00000010 and link_data=0xFFFFFFF4.
REQ-039 SHALL cover reset mid-FLUSH: rst=1 in the first flush cycle -> flush=0 next cycle and br_ready=1 after release.
